parity_frame_tx: RTL and testbench



---
 rtl/parity_frame_tx_pkg.sv | 21 ++
 rtl/parity_frame_tx_bit_timer.sv | 44 ++++
 rtl/parity_frame_tx.sv | 119 +++++++++++
 tb/tb_parity_frame_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_tx_pkg.sv
// Shared types, line levels and counter-width helper for the parity serial framer.
package parity_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module parity_frame_tx_bit_timer
    import parity_frame_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic tick_next_c
);

    localparam int unsigned CW = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // tick_next_c lets the owner register outputs that must line up with tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_next_c = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'(CLKS_PER_BIT == 1);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_next_c;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial framer: accepts a word, sends start, data LSB-first, even parity and stop bits.
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 3,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              e,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              e_q, e_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              tick_next_c;
    logic              accept_c;

    assign accept_c = valid && ready_q;

    parity_frame_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q == IDLE),
        .tick       (tick),
        .tick_next_c(tick_next_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && (bit_cnt_q == LAST_BIT)) state_d = PARITY;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs are computed for the state being entered.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        e_d       = e_q;
        if (accept_c) begin
            shift_d = a;
            e_d     = ^a;
        end
        if ((state_q == DATA) && tick) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BW'(1);
        end

        case (state_d)
            IDLE:    tx_d = IDLE_LVL;
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = e_d;
            STOP:    tx_d = STOP_LVL;
            default: tx_d = IDLE_LVL;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP) && tick_next_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            e_q       <= 1'b0;
            tx_q      <= IDLE_LVL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            e_q       <= e_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign e     = e_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench: stimulus queues hand-computed frames, per-DUT monitors check tx/e/done/ready.
module tb_parity_frame_tx;

    typedef struct packed {
        logic       e;
        logic [5:0] lv;   // line level per bit period, bit 0 = start bit
        logic       b2b;  // frame must start right after the single idle cycle
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_r   [2];
    logic       valid_r [2];
    logic [2:0] a_r     [2];
    logic       ready_w [2];
    logic       tx_w    [2];
    logic       e_w     [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst_r[0]), .a(a_r[0]), .valid(valid_r[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .e(e_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst_r[1]), .a(a_r[1]), .valid(valid_r[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .e(e_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    function automatic exp_t mk(input logic pe, input logic [5:0] lv, input logic b2b);
        exp_t x;
        x.e   = pe;
        x.lv  = lv;
        x.b2b = b2b;
        return x;
    endfunction

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input int i, input exp_t x);
        if (i == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic mon(input int i, input int cpb);
        exp_t cur;
        bit   in_frame = 1'b0;
        bit   rst_pend = 1'b1;
        int   pos      = 0;
        int   cyc      = 0;
        int   last_end = -100;
        int   len      = 6 * cpb;
        cur = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_pend) begin
                in_frame = 1'b0;
                chk(tx_w[i] === 1'b1 && busy_w[i] === 1'b0 && ready_w[i] === 1'b1 &&
                    e_w[i] === 1'b0 && done_w[i] === 1'b0, $sformatf("reset_state%0d", i),
                    int'({busy_w[i], ready_w[i], e_w[i], done_w[i], tx_w[i]}), 5'b01001);
            end else begin
                if (!in_frame && busy_w[i] === 1'b1) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        chk(1'b0, $sformatf("unexpected_frame%0d", i), 1, 0);
                    end else begin
                        cur = (i == 0) ? q0.pop_front() : q1.pop_front();
                        if (cur.b2b) chk(cyc - last_end == 2, $sformatf("b2b_gap%0d", i), cyc - last_end, 2);
                        in_frame = 1'b1;
                        pos      = 0;
                    end
                end
                if (in_frame) begin
                    chk(tx_w[i] === cur.lv[pos / cpb], $sformatf("frame_tx%0d_pos%0d", i, pos),
                        int'(tx_w[i]), int'(cur.lv[pos / cpb]));
                    chk(e_w[i] === cur.e, $sformatf("parity_e%0d", i), int'(e_w[i]), int'(cur.e));
                    chk(done_w[i] === 1'(pos == len - 1), $sformatf("done%0d_pos%0d", i, pos),
                        int'(done_w[i]), int'(pos == len - 1));
                    chk(busy_w[i] === 1'b1 && ready_w[i] === 1'b0, $sformatf("busy_ready%0d", i),
                        int'({busy_w[i], ready_w[i]}), 2);
                    pos++;
                    if (pos == len) begin
                        in_frame = 1'b0;
                        last_end = cyc;
                    end
                end else if (busy_w[i] !== 1'b1) begin
                    chk(tx_w[i] === 1'b1 && done_w[i] === 1'b0 && ready_w[i] === 1'b1,
                        $sformatf("idle%0d", i), int'({ready_w[i], done_w[i], tx_w[i]}), 3'b101);
                end
            end
            rst_pend = rst_r[i];
        end
    endtask

    task automatic send(input int i, input logic [2:0] w, input exp_t x);
        int t = 0;
        while (ready_w[i] !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk(ready_w[i] === 1'b1, $sformatf("ready_wait%0d", i), t, 0);
        push(i, x);
        a_r[i]     = w;
        valid_r[i] = 1'b1;
        @(posedge clk); #1;
        valid_r[i] = 1'b0;
        a_r[i]     = 3'($urandom);
    endtask

    initial mon(0, 4);
    initial mon(1, 1);

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 2; i++) begin
            rst_r[i]   = 1'b1;
            valid_r[i] = 1'b0;
            a_r[i]     = 3'b000;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_r[0] = 1'b0;
        rst_r[1] = 1'b0;

        send(0, 3'b101, mk(1'b0, 6'b101010, 1'b0));
        send(0, 3'b111, mk(1'b1, 6'b111110, 1'b0));
        send(0, 3'b000, mk(1'b0, 6'b100000, 1'b0));

        // Valid held through a frame: second word waits for the idle cycle.
        send(0, 3'b110, mk(1'b0, 6'b101100, 1'b0));
        push(0, mk(1'b1, 6'b110010, 1'b1));
        a_r[0]     = 3'b001;
        valid_r[0] = 1'b1;
        t = 0;
        while (ready_w[0] !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk(ready_w[0] === 1'b1, "held_valid_ready", t, 0);
        @(posedge clk); #1;
        valid_r[0] = 1'b0;

        // Reset during data bit 1, then a clean frame.
        send(0, 3'b010, mk(1'b1, 6'b110100, 1'b0));
        repeat (9) @(posedge clk);
        #1;
        rst_r[0] = 1'b1;
        @(posedge clk); #1;
        rst_r[0] = 1'b0;
        send(0, 3'b100, mk(1'b1, 6'b111000, 1'b0));

        send(1, 3'b011, mk(1'b0, 6'b100110, 1'b0));

        // Valid held with reset: accepted on the first edge after release.
        t = 0;
        while (ready_w[0] !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        push(0, mk(1'b0, 6'b100110, 1'b0));
        rst_r[0]   = 1'b1;
        valid_r[0] = 1'b1;
        a_r[0]     = 3'b011;
        repeat (3) @(posedge clk);
        #1;
        rst_r[0] = 1'b0;
        @(posedge clk); #1;
        chk(busy_w[0] === 1'b1 && tx_w[0] === 1'b0, "accept_after_reset",
            int'({busy_w[0], tx_w[0]}), 2);
        valid_r[0] = 1'b0;

        t = 0;
        while (t < 300) begin
            @(posedge clk); #1;
            t++;
            if (q0.size() == 0 && q1.size() == 0 && ready_w[0] === 1'b1 && ready_w[1] === 1'b1) break;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(q0.size() == 0 && q1.size() == 0 && t < 300, "queue_drained", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
